// File: rtl/teclado_pkg.sv
// Shared types for the door-lock keypad controller: key codes, debounce
// states and the row/column to key code mapping.
package teclado_pkg;

    typedef enum logic [3:0] {
        KEY_0     = 4'd0,
        KEY_1     = 4'd1,
        KEY_2     = 4'd2,
        KEY_3     = 4'd3,
        KEY_4     = 4'd4,
        KEY_5     = 4'd5,
        KEY_6     = 4'd6,
        KEY_7     = 4'd7,
        KEY_8     = 4'd8,
        KEY_9     = 4'd9,
        KEY_CLEAR = 4'd10,
        KEY_ENTER = 4'd11,
        KEY_NONE  = 4'd12,
        KEY_MULTI = 4'd13
    } key_code_t;

    typedef enum logic {
        DEB_RELEASED = 1'b0,
        DEB_PRESSED  = 1'b1
    } deb_state_t;

    // Letter keys A-D fall through to KEY_NONE so they are never accepted.
    function automatic key_code_t map_key(input logic [1:0] row, input logic [1:0] col);
        key_code_t code;
        case ({row, col})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hC:    code = KEY_CLEAR;
            4'hD:    code = KEY_0;
            4'hE:    code = KEY_ENTER;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    function automatic logic is_key(input key_code_t code);
        return code <= KEY_ENTER;
    endfunction

    function automatic logic is_digit(input key_code_t code);
        return code <= KEY_9;
    endfunction

endpackage

// File: rtl/teclado_scan.sv
// Matrix row scanner with per-scan key classification and a press/release
// debounce FSM; emits a one-cycle key_evt with the accepted key_code.
module teclado_scan
    import teclado_pkg::*;
#(
    parameter int SCAN_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] col,
    output logic [3:0] lin,
    output logic       key_evt,
    output key_code_t  key_code,
    output deb_state_t state
);

    localparam int CYC_W = $clog2(SCAN_CYCLES);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [CYC_W-1:0] cyc;
    logic [1:0]       row;
    logic [1:0]       row_nx;
    logic [3:0]       col_q;
    logic [1:0]       acc_cnt;
    logic [1:0]       acc_cnt_nx;
    key_code_t        acc_code;
    key_code_t        acc_code_nx;
    key_code_t        cand_code;
    logic [DEB_W-1:0] match_cnt;
    logic [DEB_W-1:0] run;
    logic [DEB_W-1:0] rel_run;
    logic [2:0]       row_hits;
    logic [2:0]       total;
    key_code_t        row_code;
    key_code_t        scan_code;
    logic             sample;
    logic             scan_done;

    assign sample    = (cyc == CYC_W'(SCAN_CYCLES - 1));
    assign scan_done = sample && (row == 2'd3);
    assign row_nx    = sample ? row + 2'd1 : row;

    // Closed switches are counted across the whole scan so two keys on
    // different rows still classify as MULTI.
    always_comb begin
        row_hits = 3'd0;
        row_code = KEY_NONE;
        for (int c = 0; c < 4; c++) begin
            if (!col_q[c]) begin
                row_hits = row_hits + 3'd1;
                row_code = map_key(row, c[1:0]);
            end
        end
        total       = {1'b0, acc_cnt} + row_hits;
        acc_cnt_nx  = (total >= 3'd2) ? 2'd2 : total[1:0];
        acc_code_nx = (acc_cnt == 2'd0) ? row_code : acc_code;
        if (total == 3'd0) begin
            scan_code = KEY_NONE;
        end else if (total == 3'd1) begin
            scan_code = acc_code_nx;
        end else begin
            scan_code = KEY_MULTI;
        end
        run     = (match_cnt != '0 && scan_code == cand_code) ? match_cnt + 1'b1 : DEB_W'(1);
        rel_run = match_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc       <= '0;
            row       <= 2'd0;
            lin       <= 4'b1110;
            col_q     <= 4'hF;
            acc_cnt   <= 2'd0;
            acc_code  <= KEY_NONE;
            cand_code <= KEY_NONE;
            match_cnt <= '0;
            state     <= DEB_RELEASED;
            key_evt   <= 1'b0;
            key_code  <= KEY_NONE;
        end else if (!en) begin
            // A key held across re-enable must be released before it counts.
            cyc       <= '0;
            row       <= 2'd0;
            lin       <= 4'b1111;
            col_q     <= col;
            acc_cnt   <= 2'd0;
            acc_code  <= KEY_NONE;
            match_cnt <= '0;
            state     <= DEB_PRESSED;
            key_evt   <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            col_q   <= col;
            row     <= row_nx;
            lin     <= ~(4'b0001 << row_nx);
            cyc     <= sample ? '0 : cyc + 1'b1;
            if (sample) begin
                acc_cnt  <= scan_done ? 2'd0 : acc_cnt_nx;
                acc_code <= scan_done ? KEY_NONE : acc_code_nx;
            end
            if (scan_done) begin
                case (state)
                    DEB_RELEASED: begin
                        if (!is_key(scan_code)) begin
                            match_cnt <= '0;
                        end else if (run == DEB_W'(DEBOUNCE_SCANS)) begin
                            state     <= DEB_PRESSED;
                            match_cnt <= '0;
                            key_evt   <= 1'b1;
                            key_code  <= scan_code;
                        end else begin
                            match_cnt <= run;
                            cand_code <= scan_code;
                        end
                    end
                    DEB_PRESSED: begin
                        if (is_key(scan_code)) begin
                            match_cnt <= '0;
                        end else if (rel_run == DEB_W'(DEBOUNCE_SCANS)) begin
                            state     <= DEB_RELEASED;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= rel_run;
                        end
                    end
                    default: state <= DEB_RELEASED;
                endcase
            end
        end
    end

endmodule

// File: rtl/teclado_ctrl.sv
// Keypad controller: digit buffer, '#'/'*' handling and delivery routing to
// the operational or setup FSM. Define TECLADO_TIMEOUT_EN for entry timeout.
module teclado_ctrl
    import teclado_pkg::*;
#(
    parameter int SCAN_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 250,
    parameter int MAX_DIGITS     = 20,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               teclado_en,
    input  logic                               setup_on,
    input  logic [3:0]                         matricial_col,
    output logic [3:0]                         matricial_lin,
    output logic [4*MAX_DIGITS-1:0]            digitos_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    digitos_count,
    output logic                               op_valid,
    output logic                               setup_valid,
    output logic                               key_bip,
    output deb_state_t                         scan_state
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    if (SCAN_CYCLES < 2 || DEBOUNCE_SCANS < 1 || MAX_DIGITS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("teclado_ctrl: invalid parameter set");
    end

    logic                    key_evt;
    key_code_t               key_code;
    logic                    setup_q;
    logic                    timeout_hit;
    logic                    clr;
    logic [4*MAX_DIGITS-1:0] base_value;
    logic [4*MAX_DIGITS-1:0] value_nx;
    logic [CNT_W-1:0]        base_count;
    logic [CNT_W-1:0]        count_nx;
    logic                    op_nx;
    logic                    setup_nx;
    logic                    bip_nx;

    teclado_scan #(
        .SCAN_CYCLES    (SCAN_CYCLES),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .en       (teclado_en),
        .col      (matricial_col),
        .lin      (matricial_lin),
        .key_evt  (key_evt),
        .key_code (key_code),
        .state    (scan_state)
    );

`ifdef TECLADO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && (digitos_count != '0) && !key_evt;

    always_ff @(posedge clk) begin
        if (rst || !teclado_en || key_evt || digitos_count == '0 || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A delivered entry, a consumer switch or a timeout empties the buffer
    // before this cycle's key event is applied.
    always_comb begin
        clr        = (setup_on != setup_q) || op_valid || setup_valid || timeout_hit;
        base_value = clr ? '0 : digitos_value;
        base_count = clr ? '0 : digitos_count;
        value_nx   = base_value;
        count_nx   = base_count;
        op_nx      = 1'b0;
        setup_nx   = 1'b0;
        bip_nx     = 1'b0;
        if (!teclado_en) begin
            value_nx = '0;
            count_nx = '0;
        end else if (key_evt) begin
            if (is_digit(key_code)) begin
                value_nx = {base_value[4*MAX_DIGITS-5:0], 4'(key_code)};
                count_nx = (base_count == CNT_W'(MAX_DIGITS)) ? base_count : base_count + 1'b1;
                bip_nx   = 1'b1;
            end else if (key_code == KEY_CLEAR) begin
                value_nx = '0;
                count_nx = '0;
                bip_nx   = 1'b1;
            end else if (key_code == KEY_ENTER && setup_on == setup_q && base_count != '0) begin
                op_nx    = !setup_on;
                setup_nx = setup_on;
                bip_nx   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digitos_value <= '0;
            digitos_count <= '0;
            op_valid      <= 1'b0;
            setup_valid   <= 1'b0;
            key_bip       <= 1'b0;
            setup_q       <= setup_on;
        end else begin
            digitos_value <= value_nx;
            digitos_count <= count_nx;
            op_valid      <= op_nx;
            setup_valid   <= setup_nx;
            key_bip       <= bip_nx;
            setup_q       <= setup_on;
        end
    end

endmodule

// File: tb/tb_teclado_ctrl.sv
// Bench for teclado_ctrl: keypad matrix model, key tap driver, delivery
// scoreboard and a final summary line.
module tb_teclado_ctrl;

    localparam int SC    = 4;
    localparam int DS    = 3;
    localparam int MD    = 4;
    localparam int TO    = 200;
    localparam int HOLD  = 5 * 4 * SC;
    localparam int SCAN  = 4 * SC;

    logic        clk;
    logic        rst;
    logic        teclado_en;
    logic        setup_on;
    logic [3:0]  matricial_col;
    logic [3:0]  matricial_lin;
    logic [15:0] digitos_value;
    logic [2:0]  digitos_count;
    logic        op_valid;
    logic        setup_valid;
    logic        key_bip;
    logic        scan_state;

    logic [15:0] keys;
    logic [21:0] exp_q[$];
    logic [21:0] obs_q[$];
    logic [31:0] post_q[$];
    logic        post_pending;
    int          bip_seen;
    int          exp_bips;
    int          n_checks;
    int          n_errors;
    logic [15:0] m_val;
    int          m_cnt;
    int          b0;

    teclado_ctrl #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_SCANS (DS),
        .MAX_DIGITS     (MD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .teclado_en    (teclado_en),
        .setup_on      (setup_on),
        .matricial_col (matricial_col),
        .matricial_lin (matricial_lin),
        .digitos_value (digitos_value),
        .digitos_count (digitos_count),
        .op_valid      (op_valid),
        .setup_valid   (setup_valid),
        .key_bip       (key_bip),
        .scan_state    (scan_state)
    );

    // clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix: a closed switch pulls its column low while its row is driven
    always_comb begin
        matricial_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!matricial_lin[r] && keys[r*4+c]) matricial_col[c] = 1'b0;
            end
        end
    end

    // output monitor
    initial begin
        bip_seen     = 0;
        post_pending = 1'b0;
    end
    always @(negedge clk) begin
        if (post_pending) post_q.push_back(32'(digitos_count));
        post_pending = !rst && (op_valid || setup_valid);
        if (!rst && key_bip) bip_seen = bip_seen + 1;
        if (!rst && (op_valid || setup_valid))
            obs_q.push_back({op_valid, setup_valid, key_bip, digitos_count, digitos_value});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drain();
        logic [21:0] got;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            if (exp_q.size() == 0) check("unexpected_strobe", 32'(got), 32'd0);
            else check("delivery", 32'(got), 32'(exp_q.pop_front()));
        end
        while (post_q.size() > 0) check("clear_after_strobe", post_q.pop_front(), 32'd0);
    endtask

    task automatic key_idx(input int k, output int idx);
        case (k)
            1: idx = 0;   2: idx = 1;   3: idx = 2;
            4: idx = 4;   5: idx = 5;   6: idx = 6;
            7: idx = 8;   8: idx = 9;   9: idx = 10;
            10: idx = 12; 0: idx = 13;  default: idx = 14;
        endcase
    endtask

    task automatic model_clear();
        m_val = 16'h0;
        m_cnt = 0;
    endtask

    // k: 0-9 digit, 10 = '*', 11 = '#'
    task automatic tap(input int k);
        int idx;
        key_idx(k, idx);
        if (k <= 9) begin
            m_val = {m_val[11:0], 4'(k)};
            if (m_cnt < MD) m_cnt = m_cnt + 1;
            exp_bips = exp_bips + 1;
        end else if (k == 10) begin
            model_clear();
            exp_bips = exp_bips + 1;
        end else if (m_cnt > 0) begin
            exp_q.push_back({~setup_on, setup_on, 1'b1, 3'(m_cnt), m_val});
            model_clear();
            exp_bips = exp_bips + 1;
        end
        keys[idx] = 1'b1;
        repeat (HOLD) @(negedge clk);
        keys = '0;
        repeat (HOLD) @(negedge clk);
        drain();
        check("count", 32'(digitos_count), 32'(m_cnt));
        check("value", 32'(digitos_value), 32'(m_val));
        check("bips", 32'(bip_seen), 32'(exp_bips));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_bips   = 0;
        keys       = '0;
        rst        = 1'b1;
        teclado_en = 1'b1;
        setup_on   = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_lin", 32'(matricial_lin), 32'hE);
        check("rst_count", 32'(digitos_count), 32'd0);
        check("rst_value", 32'(digitos_value), 32'd0);
        check("rst_strobes", {29'd0, op_valid, setup_valid, key_bip}, 32'd0);
        check("rst_state", 32'(scan_state), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // clean entry delivered to operational
        tap(1); tap(2); tap(3);
        check("entry_123", 32'(digitos_value), 32'h0123);
        tap(11);

        // bouncing key 5: never three consecutive closed scans
        b0 = bip_seen;
        for (int i = 0; i < 3; i++) begin
            keys[5] = 1'b1;
            repeat (2 * SCAN) @(negedge clk);
            keys[5] = 1'b0;
            repeat (SCAN) @(negedge clk);
        end
        check("bounce_no_bip", 32'(bip_seen), 32'(b0));
        check("bounce_count", 32'(digitos_count), 32'd0);
        tap(5);
        tap(10);

        // saturation keeps the newest MAX_DIGITS digits
        for (int d = 1; d <= 6; d++) tap(d);
        check("sat_value", 32'(digitos_value), 32'h3456);
        tap(11);

        // consumer switch clears a partial entry
        tap(7); tap(8);
        setup_on = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check("switch_clear", 32'(digitos_count), 32'd0);
        tap(9); tap(11);
        setup_on = 1'b0;
        repeat (3) @(negedge clk);

        // two keys together are ignored; '#' on empty buffer is ignored
        b0 = bip_seen;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        repeat (10 * SCAN) @(negedge clk);
        check("multi_no_bip", 32'(bip_seen), 32'(b0));
        keys = '0;
        repeat (HOLD) @(negedge clk);
        tap(11);

        // inactivity
        tap(4);
        repeat (150) @(negedge clk);
`ifdef TECLADO_TIMEOUT_EN
        model_clear();
`endif
        check("idle_count", 32'(digitos_count), 32'(m_cnt));
        tap(11);

        // disable clears, forces a release before the next key
        tap(3);
        teclado_en = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("dis_lin", 32'(matricial_lin), 32'hF);
        check("dis_count", 32'(digitos_count), 32'd0);
        keys[6] = 1'b1;
        repeat (2 * SCAN) @(negedge clk);
        teclado_en = 1'b1;
        b0 = bip_seen;
        repeat (10 * SCAN) @(negedge clk);
        check("reen_no_bip", 32'(bip_seen), 32'(b0));
        check("reen_state", 32'(scan_state), 32'd1);
        keys = '0;
        repeat (HOLD) @(negedge clk);
        check("release_state", 32'(scan_state), 32'd0);
        tap(6);
        tap(10);

        // reset mid-entry
        tap(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        check("midrst_count", 32'(digitos_count), 32'd0);
        check("midrst_lin", 32'(matricial_lin), 32'hE);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tap(8); tap(11);

        drain();
        check("pending_deliveries", 32'(exp_q.size()), 32'd0);
        check("bip_total", 32'(bip_seen), 32'(exp_bips));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
